// File: rtl/prog_image_stream_loader.sv
// Parses a Verilog-hex memory-image character stream and turns it into
// word-aligned, byte-strobed memory writes.
module prog_image_stream_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                ch_valid_i,
  input  logic [7:0]          ch_i,
  input  logic                ch_last_i,
  output logic                ch_ready_o,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  output logic                done_o,
  output logic                err_o,
  output logic [31:0]         byte_cnt_o
);
  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned TOK_W  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int unsigned MAX_AD = ADDR_W / 4;
  localparam int unsigned CNT_W  = $clog2(MAX_AD + 2);

  typedef enum logic [2:0] {S_IDLE, S_SEP, S_DATA, S_ADDR, S_FLUSH, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [TOK_W-1:0]    tok_q, tok_d, tok_acc, tok_done;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d, new_addr_q, new_addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   lane, aligned;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic [31:0]         byte_cnt_q, byte_cnt_d;
  logic                addr_pend_q, addr_pend_d, last_pend_q, last_pend_d;
  logic                ch_ready_q, wr_valid_q, done_q, err_q;
  logic                is_hex, is_ws, is_at, accept, do_byte, do_addr, fin;
  logic [3:0]          hex_val;

  // Character classification
  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'h0;
    if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = 4'(ch_i - 8'h30);
    end else if (ch_i >= 8'h61 && ch_i <= 8'h66) begin
      is_hex  = 1'b1;
      hex_val = 4'(ch_i - 8'h57);
    end else if (ch_i >= 8'h41 && ch_i <= 8'h46) begin
      is_hex  = 1'b1;
      hex_val = 4'(ch_i - 8'h37);
    end
    is_ws = (ch_i == 8'h20) || (ch_i == 8'h09) || (ch_i == 8'h0A) || (ch_i == 8'h0D);
    is_at = (ch_i == 8'h40);
  end

  assign accept  = ch_valid_i && ch_ready_q;
  assign tok_acc = (tok_q << 4) | TOK_W'(hex_val);
  assign lane    = cursor_q % ADDR_W'(NB);
  assign aligned = cursor_q & ~ADDR_W'(NB - 1);

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    cnt_d       = cnt_q;
    cursor_d    = cursor_q;
    new_addr_d  = new_addr_q;
    wr_addr_d   = wr_addr_q;
    buf_d       = buf_q;
    strb_d      = strb_q;
    byte_cnt_d  = byte_cnt_q;
    addr_pend_d = addr_pend_q;
    last_pend_d = last_pend_q;
    tok_done    = tok_q;
    do_byte     = 1'b0;
    do_addr     = 1'b0;
    fin         = 1'b0;

    unique case (state_q)
      S_SEP: if (accept) begin
        if (is_hex) begin
          tok_d = TOK_W'(hex_val);
          cnt_d = CNT_W'(1);
          if (ch_last_i) begin
            do_byte  = 1'b1;
            tok_done = TOK_W'(hex_val);
            fin      = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end else if (is_at) begin
          tok_d   = '0;
          cnt_d   = '0;
          state_d = ch_last_i ? S_ERR : S_ADDR;
        end else if (is_ws) begin
          fin = ch_last_i;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DATA: if (accept) begin
        if (is_hex) begin
          if (cnt_q == CNT_W'(2)) begin
            state_d = S_ERR;
          end else begin
            tok_d = tok_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (ch_last_i) begin
              do_byte  = 1'b1;
              tok_done = tok_acc;
              fin      = 1'b1;
            end
          end
        end else if (is_ws) begin
          do_byte = 1'b1;
          fin     = ch_last_i;
        end else begin
          state_d = S_ERR;
        end
      end
      S_ADDR: if (accept) begin
        if (is_hex) begin
          if (cnt_q == CNT_W'(MAX_AD)) begin
            state_d = S_ERR;
          end else begin
            tok_d = tok_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (ch_last_i) begin
              do_addr  = 1'b1;
              tok_done = tok_acc;
              fin      = 1'b1;
            end
          end
        end else if (is_ws && cnt_q != '0) begin
          do_addr = 1'b1;
          fin     = ch_last_i;
        end else begin
          state_d = S_ERR;
        end
      end
      S_FLUSH: if (wr_ready_i) begin
        buf_d       = '0;
        strb_d      = '0;
        addr_pend_d = 1'b0;
        if (addr_pend_q) cursor_d = new_addr_q;
        state_d = last_pend_q ? S_DONE : S_SEP;
      end
      default: ;
    endcase

    // Commit the completed token; a flush always uses the current word address
    if (do_byte) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (lane == ADDR_W'(i)) begin
          buf_d[i*8 +: 8] = tok_done[7:0];
          strb_d[i]       = 1'b1;
        end
      end
      wr_addr_d  = aligned;
      cursor_d   = cursor_q + ADDR_W'(1);
      byte_cnt_d = byte_cnt_q + 32'd1;
      if (lane == ADDR_W'(NB - 1) || fin) begin
        state_d     = S_FLUSH;
        last_pend_d = fin;
      end else begin
        state_d = S_SEP;
      end
    end else if (do_addr) begin
      if (strb_q != '0) begin
        wr_addr_d   = aligned;
        new_addr_d  = tok_done[ADDR_W-1:0];
        addr_pend_d = 1'b1;
        last_pend_d = fin;
        state_d     = S_FLUSH;
      end else begin
        cursor_d = tok_done[ADDR_W-1:0];
        state_d  = fin ? S_DONE : S_SEP;
      end
    end else if (fin) begin
      if (strb_q != '0) begin
        wr_addr_d   = aligned;
        last_pend_d = 1'b1;
        state_d     = S_FLUSH;
      end else begin
        state_d = S_DONE;
      end
    end

    // A new load overrides everything, including a pending write
    if (start_i) begin
      state_d     = S_SEP;
      tok_d       = '0;
      cnt_d       = '0;
      cursor_d    = '0;
      new_addr_d  = '0;
      wr_addr_d   = '0;
      buf_d       = '0;
      strb_d      = '0;
      byte_cnt_d  = '0;
      addr_pend_d = 1'b0;
      last_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tok_q       <= '0;
      cnt_q       <= '0;
      cursor_q    <= '0;
      new_addr_q  <= '0;
      wr_addr_q   <= '0;
      buf_q       <= '0;
      strb_q      <= '0;
      byte_cnt_q  <= '0;
      addr_pend_q <= 1'b0;
      last_pend_q <= 1'b0;
      ch_ready_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      cnt_q       <= cnt_d;
      cursor_q    <= cursor_d;
      new_addr_q  <= new_addr_d;
      wr_addr_q   <= wr_addr_d;
      buf_q       <= buf_d;
      strb_q      <= strb_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_pend_q <= addr_pend_d;
      last_pend_q <= last_pend_d;
      ch_ready_q  <= (state_d == S_SEP) || (state_d == S_DATA) || (state_d == S_ADDR);
      wr_valid_q  <= (state_d == S_FLUSH);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign ch_ready_o = ch_ready_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = buf_q;
  assign wr_strb_o  = strb_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign byte_cnt_o = byte_cnt_q;
endmodule

// File: tb/tb_prog_image_stream_loader.sv
// Directed bench for prog_image_stream_loader: hex-image parsing, flushes,
// backpressure, errors and reset.
module tb_prog_image_stream_loader;
  logic        clk = 1'b0;
  logic        rst_n, start, ch_valid, ch_last, ch_ready, wr_valid, wr_ready, done, err;
  logic [7:0]  ch;
  logic [31:0] wr_addr, wr_data, byte_cnt;
  logic [3:0]  wr_strb;
  int          checks = 0;
  int          failures = 0;
  logic [67:0] wq[$];

  always #5 clk = ~clk;

  prog_image_stream_loader #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ch_valid_i(ch_valid), .ch_i(ch),
    .ch_last_i(ch_last), .ch_ready_o(ch_ready), .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_strb_o(wr_strb), .done_o(done),
    .err_o(err), .byte_cnt_o(byte_cnt)
  );

  // Record every completed write
  always @(posedge clk) if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data, wr_strb});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input logic last);
    int n = 0;
    ch_valid = 1'b1;
    ch = c;
    ch_last = last;
    while (!ch_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ch_ready) begin
      checks++;
      failures++;
      $display("FAIL send_char_timeout char=%h ready=%b", c, ch_ready);
    end else begin
      tick();
    end
    ch_valid = 1'b0;
    ch_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_end);
    for (int i = 0; i < s.len(); i++) send_char(s[i], last_on_end && (i == s.len() - 1));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done got=%b exp=1", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ch_valid = 1'b0; ch = 8'h0; ch_last = 1'b0; wr_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({ch_ready, wr_valid, done, err, wr_addr, wr_data, wr_strb, byte_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b %h %h %h %h exp=all zero",
               ch_ready, wr_valid, done, err, wr_addr, wr_data, wr_strb, byte_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (ch_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready got=%b exp=0", ch_ready);
    end
  endtask

  task automatic test_full_word();
    logic [67:0] got;
    pulse_start();
    wq.delete();
    send_str("@10 AA BB CC DD", 1'b1);
    wait_done("full_word");
    got = (wq.size() > 0) ? wq[0] : 'x;
    checks++;
    if (wq.size() != 1 || got !== {32'h10, 32'hDDCCBBAA, 4'hF}) begin
      failures++;
      $display("FAIL full_word_write n=%0d got=%h exp=1 x %h", wq.size(), got, {32'h10, 32'hDDCCBBAA, 4'hF});
    end
    checks++;
    if (byte_cnt !== 32'd4 || ch_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_word_cnt got=%0d ready=%b exp=4 ready=0", byte_cnt, ch_ready);
    end
  endtask

  task automatic test_partial_words();
    logic [67:0] got0, got1;
    pulse_start();
    wq.delete();
    send_str("@3 11 22\n", 1'b1);
    wait_done("partial");
    got0 = (wq.size() > 0) ? wq[0] : 'x;
    got1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++;
    if (got0 !== {32'h0, 32'h11000000, 4'h8}) begin
      failures++;
      $display("FAIL partial_w0 got=%h exp=%h", got0, {32'h0, 32'h11000000, 4'h8});
    end
    checks++;
    if (got1 !== {32'h4, 32'h00000022, 4'h1} || wq.size() != 2) begin
      failures++;
      $display("FAIL partial_w1 n=%0d got=%h exp=%h", wq.size(), got1, {32'h4, 32'h00000022, 4'h1});
    end
  endtask

  task automatic test_addr_flush();
    logic [67:0] got0, got1;
    pulse_start();
    wq.delete();
    send_str("AA @20 BB", 1'b1);
    wait_done("addr_flush");
    got0 = (wq.size() > 0) ? wq[0] : 'x;
    got1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++;
    if (got0 !== {32'h0, 32'hAA, 4'h1} || got1 !== {32'h20, 32'hBB, 4'h1} || wq.size() != 2) begin
      failures++;
      $display("FAIL addr_flush n=%0d got=%h,%h exp=%h,%h", wq.size(), got0, got1,
               {32'h0, 32'hAA, 4'h1}, {32'h20, 32'hBB, 4'h1});
    end
    // Same address as the cursor still flushes the partial word
    pulse_start();
    wq.delete();
    send_str("@0 AA @0 BB", 1'b1);
    wait_done("same_addr");
    got0 = (wq.size() > 0) ? wq[0] : 'x;
    got1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++;
    if (got0 !== {32'h0, 32'hAA, 4'h1} || got1 !== {32'h0, 32'hBB, 4'h1} || wq.size() != 2) begin
      failures++;
      $display("FAIL same_addr n=%0d got=%h,%h", wq.size(), got0, got1);
    end
  endtask

  task automatic test_wrap();
    logic [67:0] got0, got1;
    pulse_start();
    wq.delete();
    send_str("@FFFFFFFF 11 22", 1'b1);
    wait_done("wrap");
    got0 = (wq.size() > 0) ? wq[0] : 'x;
    got1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++;
    if (got0 !== {32'hFFFFFFFC, 32'h11000000, 4'h8} || got1 !== {32'h0, 32'h22, 4'h1}) begin
      failures++;
      $display("FAIL wrap got=%h,%h exp=%h,%h", got0, got1,
               {32'hFFFFFFFC, 32'h11000000, 4'h8}, {32'h0, 32'h22, 4'h1});
    end
    // Last on a separator with nothing buffered finishes immediately
    pulse_start();
    wq.delete();
    send_str("@4 ", 1'b1);
    checks++;
    if (done !== 1'b1 || wq.size() != 0) begin
      failures++;
      $display("FAIL empty_last done=%b n=%0d exp done=1 n=0", done, wq.size());
    end
  endtask

  task automatic test_backpressure();
    logic [67:0] got;
    wr_ready = 1'b0;
    pulse_start();
    wq.delete();
    send_str("01 02 03 04 ", 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({wr_valid, wr_addr, wr_data, wr_strb, ch_ready} !== {1'b1, 32'h0, 32'h04030201, 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL stall_%0d got=%b %h %h %h ready=%b exp=1 0 04030201 f ready=0",
                 i, wr_valid, wr_addr, wr_data, wr_strb, ch_ready);
      end
      tick();
    end
    wr_ready = 1'b1;
    tick();
    got = (wq.size() > 0) ? wq[0] : 'x;
    checks++;
    if (wq.size() != 1 || got !== {32'h0, 32'h04030201, 4'hF} || wr_valid !== 1'b0 || ch_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release n=%0d got=%h valid=%b ready=%b", wq.size(), got, wr_valid, ch_ready);
    end
  endtask

  task automatic test_errors();
    pulse_start();
    wq.delete();
    send_str("11 ABC", 1'b0);
    checks++;
    if (err !== 1'b1 || ch_ready !== 1'b0 || wq.size() != 0 || byte_cnt !== 32'd1) begin
      failures++;
      $display("FAIL err_data3 err=%b ready=%b n=%0d cnt=%0d exp 1 0 0 1", err, ch_ready, wq.size(), byte_cnt);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || byte_cnt !== 32'd0 || ch_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_clear err=%b cnt=%0d ready=%b exp 0 0 1", err, byte_cnt, ch_ready);
    end
    send_str("@123456789", 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_addr_long got=%b exp=1", err);
    end
    pulse_start();
    send_str("5G", 1'b0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL err_bad_char err=%b done=%b exp 1 0", err, done);
    end
  endtask

  task automatic test_reset_mid_token();
    pulse_start();
    wq.delete();
    send_str("@8 AA", 1'b0);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ch_ready, wr_valid, done, err, wr_addr, wr_data, wr_strb, byte_cnt} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b/%b/%b %h %h %h %h exp=all zero",
               ch_ready, wr_valid, done, err, wr_addr, wr_data, wr_strb, byte_cnt);
    end
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (wq.size() != 0 || wr_valid !== 1'b0 || ch_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_nowrite n=%0d valid=%b ready=%b exp 0 0 0", wq.size(), wr_valid, ch_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_words();
    test_addr_flush();
    test_wrap();
    test_backpressure();
    test_errors();
    test_reset_mid_token();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
